toeplitz_ctrl: RTL

TOEPLITZ_CTRL -- requirements
Module: toeplitz_ctrl

---
 rtl/toeplitz_pkg.sv | 7 +
 rtl/toeplitz_fifo.sv | 45 ++++
 rtl/toeplitz_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/toeplitz_pkg.sv
// toeplitz_pkg: FSM state encoding and counter-width helper shared by the toeplitz controller and its FIFO.
package toeplitz_pkg;
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_e;
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/toeplitz_fifo.sv
// toeplitz_fifo: synchronous W-bit FIFO of DEPTH entries with an occupancy count; head word is visible on dout.
module toeplitz_fifo import toeplitz_pkg::*; #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [W-1:0]                  din,
    input  logic                          pop,
    output logic [W-1:0]                  dout,
    output logic                          full,
    output logic [cnt_w(DEPTH+1)-1:0]     count
);
    localparam int unsigned PW = cnt_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign push_ok = push && !full;
    assign pop_ok  = pop && cnt_q != '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    always_comb begin
        wr_d  = push_ok ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d  = pop_ok ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/toeplitz_ctrl.sv
// toeplitz_ctrl: buffers raw words and streams each N-bit block LSB-first into an external Toeplitz extractor,
// then captures the extractor result into a valid/ready output register.
module toeplitz_ctrl import toeplitz_pkg::*; #(
    parameter int unsigned BS    = 64,
    parameter int unsigned N     = 256,
    parameter int unsigned L     = 128,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2 * N / W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ext_reset,
    output logic         ext_data,
    input  logic [L-1:0] ext_q,
    input  logic         ext_qstrobe,
    output logic [L-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [31:0]  blk_cnt,
    output logic         err_strobe
);
    localparam int unsigned CW = cnt_w(DEPTH + 1);
    localparam int unsigned BW = cnt_w(N);
    localparam int unsigned IW = cnt_w(W);

    if (BS == 0 || N % W != 0 || DEPTH < N / W) begin : g_bad_cfg
        $error("toeplitz_ctrl: BS must be nonzero, N a multiple of W, DEPTH >= N/W");
    end

    state_e        state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [L-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   blk_cnt_q, blk_cnt_d;
    logic          err_q, err_d;
    logic [W-1:0]  word;
    logic [CW-1:0] count;
    logic          full, run, pop, start;

    toeplitz_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && !full),
        .din   (in_data),
        .pop   (pop),
        .dout  (word),
        .full  (full),
        .count (count)
    );

    assign run = state_q == RUN;
    // The word being serialised stays at the FIFO head; it is popped on its last bit so the next is ready without a bubble.
    assign pop = run && idx_q == IW'(W - 1);
    // A result being consumed this cycle frees the output slot, giving back-to-back blocks every N+2 cycles.
    assign start = enable && count >= CW'(N / W) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        bit_d       = run ? bit_q + BW'(1) : '0;
        idx_d       = (run && !pop) ? idx_q + IW'(1) : '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        blk_cnt_d   = blk_cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: state_d = start ? RUN : IDLE;
            RUN:  state_d = (bit_q == BW'(N - 1)) ? WAIT : RUN;
            WAIT: begin
                state_d = IDLE;
                if (ext_qstrobe) begin
                    out_data_d  = ext_q;
                    out_valid_d = 1'b1;
                    blk_cnt_d   = blk_cnt_q + 32'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready   = !full;
    assign ext_reset  = !run;
    assign ext_data   = run && word[idx_q];
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = state_q != IDLE;
    assign blk_cnt    = blk_cnt_q;
    assign err_strobe = err_q;
endmodule
